// File: rtl/efuse_array_ctrl.sv
// eFuse array controller: sequences per-bit program/read strobes across N_WORDS macros,
// keeps a shadow image of every word and can autoload that image after reset.
module efuse_array_ctrl #(
    parameter int DATA_W   = 32,
    parameter int N_WORDS  = 2,
    parameter int T_PGM    = 8,
    parameter int T_RD     = 4,
    parameter int AUTOLOAD = 1,
    localparam int ADDR_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr,
    input  logic                        rd,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           data_in,
    output logic                        ack,
    output logic                        busy,
    output logic                        wr_done,
    output logic                        rd_done,
    output logic                        err,
    output logic [DATA_W-1:0]           data_out,
    output logic [N_WORDS*DATA_W-1:0]   shadow,
    output logic                        boot_done,
    output logic                        pgenb,
    output logic                        strobe,
    output logic                        nr,
    output logic [DATA_W-1:0]           we,
    output logic [N_WORDS-1:0]          sel,
    input  logic                        q
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int T_MAX = (T_PGM > T_RD) ? T_PGM : T_RD;
    localparam int CNT_W = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, SCAN, DONE} state_t;

    typedef struct packed {
        logic               pgenb;
        logic               strobe;
        logic               nr;
        logic [DATA_W-1:0]  we;
        logic [N_WORDS-1:0] sel;
    } pins_t;

    localparam pins_t IDLE_PINS = '{pgenb: 1'b1, strobe: 1'b0, nr: 1'b0, we: '0, sel: '0};

    // Macro pin values for the state being entered; pgm selects program vs read polarity.
    function automatic pins_t pins_for(input state_t s, input logic pgm_mode,
                                       input logic [ADDR_W-1:0] a, input logic [BIT_W-1:0] b);
        pins_t p;
        p = IDLE_PINS;
        if (s == SETUP || s == STROBE || s == HOLD) begin
            p.pgenb  = ~pgm_mode;
            p.nr     = ~pgm_mode;
            p.strobe = (s == STROBE);
            p.sel[a] = 1'b1;
            p.we[b]  = 1'b1;
        end
        return p;
    endfunction

    state_t             state;
    pins_t              pins;
    logic               pgm;
    logic               loading;
    logic [ADDR_W-1:0]  cur_addr;
    logic [BIT_W-1:0]   bit_idx;
    logic [CNT_W-1:0]   tcnt;
    logic [DATA_W-1:0]  word_buf;

    logic [BIT_W-1:0]   next_bit;
    logic               last_bit;
    logic               last_word;
    logic               strobe_last;
    logic               cmd_ok;

    assign next_bit    = bit_idx + 1'b1;
    assign last_bit    = (bit_idx == BIT_W'(DATA_W - 1));
    assign last_word   = (cur_addr == ADDR_W'(N_WORDS - 1));
    assign strobe_last = (tcnt == (pgm ? CNT_W'(T_PGM - 1) : CNT_W'(T_RD - 1)));
    assign cmd_ok      = (wr ^ rd) && (int'(addr) < N_WORDS);

    // NOTE: macro pins come straight from a flop loaded with the next state's values, so
    // they change on the same edge as the state and the async reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pins      <= IDLE_PINS;
            pgm       <= 1'b0;
            loading   <= 1'b0;
            cur_addr  <= '0;
            bit_idx   <= '0;
            tcnt      <= '0;
            word_buf  <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            err       <= 1'b0;
            data_out  <= '0;
            shadow    <= '0;
            boot_done <= 1'b0;
        end else begin
            ack     <= 1'b0;
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!boot_done) begin
                        if (AUTOLOAD != 0) begin
                            state    <= SETUP;
                            busy     <= 1'b1;
                            pgm      <= 1'b0;
                            loading  <= 1'b1;
                            cur_addr <= '0;
                            bit_idx  <= '0;
                            pins     <= pins_for(SETUP, 1'b0, '0, '0);
                        end else begin
                            boot_done <= 1'b1;
                        end
                    end else if (cmd_ok) begin
                        ack      <= 1'b1;
                        busy     <= 1'b1;
                        pgm      <= wr;
                        cur_addr <= addr;
                        bit_idx  <= '0;
                        word_buf <= data_in;
                        if (wr && !data_in[0]) begin
                            state <= SCAN;
                            pins  <= IDLE_PINS;
                        end else begin
                            state <= SETUP;
                            pins  <= pins_for(SETUP, wr, addr, '0);
                        end
                    end else if (wr || rd) begin
                        err <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    tcnt  <= '0;
                    pins  <= pins_for(STROBE, pgm, cur_addr, bit_idx);
                end
                STROBE: begin
                    if (strobe_last) begin
                        state <= HOLD;
                        pins  <= pins_for(HOLD, pgm, cur_addr, bit_idx);
                        if (!pgm) word_buf[bit_idx] <= q;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                HOLD, SCAN: begin
                    if (last_bit) begin
                        state <= DONE;
                        pins  <= IDLE_PINS;
                        if (pgm) begin
                            wr_done <= 1'b1;
                        end else begin
                            data_out <= word_buf;
                            shadow[cur_addr*DATA_W +: DATA_W] <= word_buf;
                            if (!loading)      rd_done   <= 1'b1;
                            else if (last_word) boot_done <= 1'b1;
                        end
                    end else begin
                        bit_idx <= next_bit;
                        // Zero bits of a program word need no pulse, only a one-cycle scan.
                        if (pgm && !word_buf[next_bit]) begin
                            state <= SCAN;
                            pins  <= IDLE_PINS;
                        end else begin
                            state <= SETUP;
                            pins  <= pins_for(SETUP, pgm, cur_addr, next_bit);
                        end
                    end
                end
                DONE: begin
                    if (loading && !last_word) begin
                        cur_addr <= cur_addr + 1'b1;
                        bit_idx  <= '0;
                        state    <= SETUP;
                        pins     <= pins_for(SETUP, 1'b0, cur_addr + 1'b1, '0);
                    end else begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        loading <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    pins  <= IDLE_PINS;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pgenb  = pins.pgenb;
    assign strobe = pins.strobe;
    assign nr     = pins.nr;
    assign we     = pins.we;
    assign sel    = pins.sel;

endmodule

// File: tb/tb_efuse_array_ctrl.sv
// Scoreboard bench for efuse_array_ctrl: stimulus queues expected events and strobe pin
// records; a negedge monitor pops and compares them as the DUT produces them.
module tb_efuse_array_ctrl;

    localparam int DATA_W = 4;
    localparam int T_PGM  = 3;
    localparam int T_RD   = 2;

    typedef enum int {EV_BOOT, EV_ACK, EV_ERR, EV_WR_DONE, EV_RD_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         lat;
        logic [7:0] shadow;
        logic [3:0] dout;
        bit         chk_dout;
    } ev_t;
    typedef struct {
        logic [1:0] sel;
        logic [3:0] we;
        logic       nr;
        logic       pgenb;
    } pin_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr = 1'b0, rd = 1'b0;
    logic [0:0] addr = '0;
    logic [3:0] data_in = '0;
    logic       ack, busy, wr_done, rd_done, err, boot_done, pgenb, strobe, nr, q;
    logic [3:0] data_out, we;
    logic [7:0] shadow;
    logic [1:0] sel;

    logic        wr2 = 1'b0, rd2 = 1'b0;
    logic [1:0]  addr2 = '0;
    logic [3:0]  data_in2 = '0;
    logic        ack2, busy2, wr_done2, rd_done2, err2, boot_done2, pgenb2, strobe2, nr2;
    logic [3:0]  data_out2, we2;
    logic [11:0] shadow2;
    logic [2:0]  sel2;

    int checks = 0;
    int failures = 0;
    int cyc;
    int last_cyc = 0;
    logic prev_boot = 1'b0;
    ev_t  ev_q[$];
    pin_t pin_q[$];

    logic [3:0] fuse [2] = '{4'hA, 4'h5};

    always #5 clk = ~clk;

    efuse_array_ctrl #(.DATA_W(DATA_W), .N_WORDS(2), .T_PGM(T_PGM), .T_RD(T_RD), .AUTOLOAD(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .addr(addr), .data_in(data_in),
        .ack(ack), .busy(busy), .wr_done(wr_done), .rd_done(rd_done), .err(err),
        .data_out(data_out), .shadow(shadow), .boot_done(boot_done),
        .pgenb(pgenb), .strobe(strobe), .nr(nr), .we(we), .sel(sel), .q(q)
    );

    // Non-power-of-two array without autoload, for the address bound and boot_done at reset.
    efuse_array_ctrl #(.DATA_W(DATA_W), .N_WORDS(3), .T_PGM(T_PGM), .T_RD(T_RD), .AUTOLOAD(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr(wr2), .rd(rd2), .addr(addr2), .data_in(data_in2),
        .ack(ack2), .busy(busy2), .wr_done(wr_done2), .rd_done(rd_done2), .err(err2),
        .data_out(data_out2), .shadow(shadow2), .boot_done(boot_done2),
        .pgenb(pgenb2), .strobe(strobe2), .nr(nr2), .we(we2), .sel(sel2), .q(1'b0)
    );

    // Fuse macro model: a program strobe blows selected bits, a read strobe returns them.
    always @(posedge clk)
        if (rst_n && strobe && !pgenb)
            for (int w = 0; w < 2; w++)
                if (sel[w]) fuse[w] <= fuse[w] | we;

    always_comb begin
        q = 1'b0;
        for (int w = 0; w < 2; w++)
            for (int b = 0; b < 4; b++)
                if (sel[w] && we[b] && strobe && nr) q = fuse[w][b];
    end

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input int lat, input logic [7:0] sh,
                           input logic [3:0] dout, input bit chk);
        ev_t e;
        e.kind = k; e.lat = lat; e.shadow = sh; e.dout = dout; e.chk_dout = chk;
        ev_q.push_back(e);
    endtask

    task automatic push_strobes(input logic [1:0] s, input logic [3:0] w, input logic n,
                                input logic pg, input int cnt);
        pin_t p;
        p.sel = s; p.we = w; p.nr = n; p.pgenb = pg;
        repeat (cnt) pin_q.push_back(p);
    endtask

    task automatic push_read_pins(input int w);
        for (int b = 0; b < 4; b++) push_strobes(2'(1 << w), 4'(1 << b), 1'b1, 1'b1, T_RD);
    endtask

    task automatic score(input ev_kind_t k);
        ev_t e;
        if (ev_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event kind=%s actual=present required=none cyc=%0d", k.name(), cyc);
        end else begin
            e = ev_q.pop_front();
            check($sformatf("ev_kind_%s", e.kind.name()), 32'(k), 32'(e.kind));
            if (e.lat >= 0) check($sformatf("%s_latency", e.kind.name()), cyc - last_cyc, e.lat);
            check($sformatf("%s_shadow", e.kind.name()), 32'(shadow), 32'(e.shadow));
            if (e.chk_dout) check($sformatf("%s_data_out", e.kind.name()), 32'(data_out), 32'(e.dout));
        end
        last_cyc = cyc;
    endtask

    task automatic score_pins();
        pin_t p;
        if (pin_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual=sel%b_we%b required=none cyc=%0d", sel, we, cyc);
        end else begin
            p = pin_q.pop_front();
            check("strobe_sel", 32'(sel), 32'(p.sel));
            check("strobe_we", 32'(we), 32'(p.we));
            check("strobe_nr", 32'(nr), 32'(p.nr));
            check("strobe_pgenb", 32'(pgenb), 32'(p.pgenb));
        end
    endtask

    // Monitor: decoupled from stimulus, compares whatever the DUT presents each cycle.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            last_cyc  = 0;
            prev_boot = 1'b0;
        end else begin
            if (boot_done && !prev_boot) score(EV_BOOT);
            if (ack)     score(EV_ACK);
            if (err)     score(EV_ERR);
            if (wr_done) score(EV_WR_DONE);
            if (rd_done) score(EV_RD_DONE);
            prev_boot = boot_done;
            if (strobe) score_pins();
        end
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((ev_q.size() != 0 || pin_q.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("queue_drained", ev_q.size() + pin_q.size(), 0);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_pgenb"}, 32'(pgenb), 1);
        check({tag, "_strobe"}, 32'(strobe), 0);
        check({tag, "_nr_we_sel"}, {26'd0, nr, we, sel}, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_boot_done"}, 32'(boot_done), 0);
        check({tag, "_shadow"}, 32'(shadow), 0);
        check({tag, "_data_out"}, 32'(data_out), 0);
        check({tag, "_pulses"}, {28'd0, ack, err, wr_done, rd_done}, 0);
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #2 check_reset_pins("reset");

        // Autoload after reset: word0=A, word1=5.
        push_read_pins(0);
        push_read_pins(1);
        push_ev(EV_BOOT, 34, 8'h5A, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("boot_done_autoload0", 32'(boot_done2), 1);
        check("boot_done_autoload1_early", 32'(boot_done), 0);
        wait_drain(100);
        @(negedge clk);
        check("idle_after_boot_busy", 32'(busy), 0);

        // Program word1 with 1001; a read issued while busy must be ignored.
        push_ev(EV_ACK, -1, 8'h5A, 4'h0, 1'b0);
        push_strobes(2'b10, 4'b0001, 1'b0, 1'b0, T_PGM);
        push_strobes(2'b10, 4'b1000, 1'b0, 1'b0, T_PGM);
        push_ev(EV_WR_DONE, 12, 8'h5A, 4'h0, 1'b0);
        @(negedge clk);
        wr = 1'b1; addr = 1'b1; data_in = 4'b1001;
        @(negedge clk);
        wr = 1'b0; data_in = 4'b0000;
        @(negedge clk);
        check("busy_during_program", 32'(busy), 1);
        rd = 1'b1; addr = 1'b0;
        repeat (3) @(negedge clk);
        rd = 1'b0;
        wait_drain(100);
        @(negedge clk);

        // Read back word1: 5 | 9 = D.
        push_ev(EV_ACK, -1, 8'h5A, 4'h0, 1'b0);
        push_read_pins(1);
        push_ev(EV_RD_DONE, 16, 8'hDA, 4'hD, 1'b1);
        @(negedge clk);
        rd = 1'b1; addr = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        wait_drain(100);
        @(negedge clk);

        // Conflicting request.
        push_ev(EV_ERR, -1, 8'hDA, 4'h0, 1'b0);
        @(negedge clk);
        wr = 1'b1; rd = 1'b1; addr = 1'b0;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        wait_drain(10);
        @(negedge clk);

        // Reset during the first program strobe cycle; the fuse must stay intact.
        push_ev(EV_ACK, -1, 8'hDA, 4'h0, 1'b0);
        push_strobes(2'b01, 4'b0001, 1'b0, 1'b0, 1);
        @(negedge clk);
        wr = 1'b1; addr = 1'b0; data_in = 4'b0001;
        @(negedge clk);
        wr = 1'b0; data_in = 4'b0000;
        n = 0;
        while (!strobe && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("program_strobe_seen", 32'(strobe), 1);
        #1 rst_n = 1'b0;
        #1 check_reset_pins("midstrobe_reset");
        push_read_pins(0);
        push_read_pins(1);
        push_ev(EV_BOOT, 34, 8'hDA, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_drain(100);
        repeat (2) @(negedge clk);

        // Address bound on a 3-word array: 3 is rejected, 2 is accepted.
        rd2 = 1'b1; addr2 = 2'd3;
        @(negedge clk);
        check("d2_err_addr3", 32'(err2), 1);
        check("d2_no_ack_addr3", 32'(ack2), 0);
        addr2 = 2'd2;
        @(negedge clk);
        check("d2_ack_addr2", 32'(ack2), 1);
        check("d2_no_err_addr2", 32'(err2), 0);
        check("d2_busy_addr2", 32'(busy2), 1);
        rd2 = 1'b0;
        n = 0;
        while (!rd_done2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("d2_rd_latency", n, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
